// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: green/yellow/all-red/walk sequencing for one four-approach junction.
// Lamps, walk and cur_phase are registered from the next-state value, so they change on the same edge as state.
module traffic_phase_scheduler #(
  parameter int DWIDTH     = 14,
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 20,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int PED_CYC    = 6,
  parameter int DSHIFT     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          algo,
  input  logic [4*DWIDTH-1:0] dens,
  input  logic [3:0]          ped_req,
  input  logic [3:0]          emg_req,
  output logic [11:0]         light,
  output logic [3:0]          walk,
  output logic [1:0]          cur_phase,
  output logic [2:0]          state
);
  typedef enum logic [2:0] {IDLE = 3'd0, SELECT, GREEN, YELLOW, ALL_RED, PED, EMG} state_e;
  localparam int TW = $clog2(GREEN_MAX + PED_CYC + YELLOW_CYC + ALLRED_CYC + GREEN_MIN + 1);
  localparam logic [TW-1:0] T_MIN = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] T_YEL = TW'(YELLOW_CYC - 1);
  localparam logic [TW-1:0] T_AR  = TW'(ALLRED_CYC - 1);
  localparam logic [TW-1:0] T_PED = TW'(PED_CYC - 1);
  localparam logic [11:0]   ALL_RED_LAMPS = 12'h924;
  state_e              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d, len_q, len_d, glen;
  logic [1:0]          cur_q, cur_d, rr, pick, egrant;
  logic [3:0]          pend_q, pend_d, walk_q, walk_d;
  logic [11:0]         light_q, light_d;
  logic [DWIDTH-1:0]   best, shifted;
  logic                own, other;
  always_comb begin
    rr = cur_q + 2'd1;
    pick = rr;
    best = '0;
    for (int i = 0; i < 4; i++)
      if (2'(i) != cur_q && dens[DWIDTH*i +: DWIDTH] > best) begin
        pick = 2'(i);
        best = dens[DWIDTH*i +: DWIDTH];
      end
    if (best == '0 && dens[DWIDTH*cur_q +: DWIDTH] != '0) pick = cur_q;
    if (algo != 2'd2) pick = rr;
    shifted = dens[DWIDTH*pick +: DWIDTH] >> DSHIFT;
    glen = (algo == 2'd1 || algo == 2'd2)
         ? (shifted < DWIDTH'(GREEN_MIN) ? TW'(GREEN_MIN) : shifted > DWIDTH'(GREEN_MAX) ? TW'(GREEN_MAX) : TW'(shifted))
         : TW'(GREEN_MAX);
    egrant = emg_req[0] ? 2'd0 : emg_req[1] ? 2'd1 : emg_req[2] ? 2'd2 : 2'd3;
    own = emg_req[cur_q];
    other = |(emg_req & ~(4'b1 << cur_q));
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    len_d = len_q;
    cur_d = cur_q;
    case (state_q)
      IDLE:    state_d = en ? ALL_RED : IDLE;
      ALL_RED: if (timer_q == T_AR) state_d = !en ? IDLE : |emg_req ? EMG : |pend_q ? PED : SELECT;
      SELECT: begin
        state_d = GREEN;
        cur_d = pick;
        len_d = glen - 1'b1;
      end
      GREEN:
        // an emergency on the green approach freezes the timer and holds green
        if (!en || (!own && (timer_q == len_q || (other && timer_q >= T_MIN)))) state_d = YELLOW;
        else if (own) timer_d = timer_q;
      YELLOW:  if (timer_q == T_YEL) state_d = ALL_RED;
      PED:     if (timer_q == T_PED) state_d = ALL_RED;
      EMG:
        if (timer_q >= T_MIN && !emg_req[cur_q]) state_d = YELLOW;
        else if (timer_q >= T_MIN) timer_d = timer_q;
      default: state_d = ALL_RED;
    endcase
    if (state_q == ALL_RED && state_d == EMG) cur_d = egrant;
    if (state_d != state_q || state_q == IDLE) timer_d = '0;
    light_d = ALL_RED_LAMPS;
    light_d[3*cur_d +: 3] = (state_d == GREEN || state_d == EMG) ? 3'b001 : state_d == YELLOW ? 3'b010 : 3'b100;
    walk_d = state_d == PED ? (state_q == PED ? walk_q : pend_q) : 4'b0;
    pend_d = (pend_q | ped_req) & ~(state_q == PED && state_d != PED ? walk_q : 4'b0);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= ALL_RED;
      timer_q <= '0;
      len_q   <= '0;
      cur_q   <= 2'd3;
      pend_q  <= '0;
      walk_q  <= '0;
      light_q <= ALL_RED_LAMPS;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      len_q   <= len_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      walk_q  <= walk_d;
      light_q <= light_d;
    end
  assign light = light_q;
  assign walk = walk_q;
  assign cur_phase = cur_q;
  assign state = state_q;
endmodule
